microbot_nav_pwm_ctrl: RTL and testbench

Parametrised successor of the microbot obstacle-avoidance controller. It synchronises and debounces three obstacle sensors and runs a five-state navigation FSM with minimum dwell and timed back-off. It drives two H-bridge motors with shoot-through-safe, PWM-modulated direction signals. It sits between the sensor pads and the motor driver pins in the top-level wrapper.

---
 rtl/microbot_nav_pwm_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_microbot_nav_pwm_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/microbot_nav_pwm_ctrl.sv
// rtl/microbot_nav_pwm_ctrl.sv - obstacle-avoidance navigation FSM with debounced sensors and PWM H-bridge drive
// Optional feature macro DEADTIME_EN: per-motor dead-time on fwd<->rev reversal.
module microbot_nav_pwm_ctrl #(
    parameter int PWM_W        = 8,
    parameter int DEBOUNCE_CYC = 4,
    parameter int MIN_DWELL    = 16,
    parameter int BACKUP_CYC   = 32,
    parameter int CNT_W        = 8,
    parameter int DUTY_RST     = 128,
    parameter int DEADTIME_CYC = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       sens_raw,
    input  logic [PWM_W-1:0] duty_in,
    input  logic             duty_load,
    output logic [3:0]       motor_out,
    output logic [2:0]       state_o,
    output logic [2:0]       sens_db,
    output logic [CNT_W-1:0] backup_cnt
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYC + 1);
    localparam int TMR_MAX = (MIN_DWELL > BACKUP_CYC) ? MIN_DWELL : BACKUP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    if (DEBOUNCE_CYC < 1 || MIN_DWELL < 1 || BACKUP_CYC < 1 || DEADTIME_CYC < 1) begin : g_param_check
        $error("microbot_nav_pwm_ctrl: cycle-count parameters must be >= 1");
    end

    typedef enum logic [2:0] {
        ST_STANDBY = 3'd0,
        ST_FORWARD = 3'd1,
        ST_RIGHT   = 3'd2,
        ST_LEFT    = 3'd3,
        ST_BACKUP  = 3'd4
    } state_t;

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  tmr, tmr_nxt;
    logic              backup_entry;
    logic [2:0]        sync1, sync2;
    logic [DB_W-1:0]   db_cnt [3];
    logic [PWM_W-1:0]  pwm_cnt, duty, duty_pend;
    logic              pwm_on;
    logic [1:0]        cmd [2];
    logic [1:0]        mot [2];

    // Sensor path: 2-flop synchroniser, then a per-bit run-length counter of disagreement with sens_db.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= '0;
            sync2   <= '0;
            sens_db <= '0;
            for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= sens_raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == sens_db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                    sens_db[i] <= sync2[i];
                    db_cnt[i]  <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    function automatic state_t decide(input logic [2:0] s);
        if (!s[2] && (s[1] == s[0])) return ST_FORWARD;
        else if (s == 3'b111)        return ST_BACKUP;
        else if (s[1] && !s[0])      return ST_RIGHT;
        else if (s == 3'b100)        return ST_RIGHT;
        else                         return ST_LEFT;
    endfunction

    always_comb begin
        state_nxt    = state;
        tmr_nxt      = tmr;
        backup_entry = 1'b0;
        if (!en) begin
            state_nxt = ST_STANDBY;
            tmr_nxt   = '0;
        end else begin
            case (state)
                ST_STANDBY: state_nxt = decide(sens_db);
                ST_FORWARD, ST_RIGHT, ST_LEFT: begin
                    if (tmr != '0) tmr_nxt = tmr - TMR_W'(1);
                    else           state_nxt = decide(sens_db);
                end
                ST_BACKUP: begin
                    if (tmr != '0) tmr_nxt = tmr - TMR_W'(1);
                    else           state_nxt = ST_RIGHT;
                end
                default: state_nxt = ST_STANDBY;
            endcase
            // Timer reloads only on a real state change; re-selecting the same state keeps it at zero.
            if (state_nxt != state) begin
                case (state_nxt)
                    ST_STANDBY: tmr_nxt = '0;
                    ST_BACKUP: begin
                        tmr_nxt      = TMR_W'(BACKUP_CYC - 1);
                        backup_entry = 1'b1;
                    end
                    default:    tmr_nxt = TMR_W'(MIN_DWELL - 1);
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_STANDBY;
            tmr        <= '0;
            backup_cnt <= '0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            if (backup_entry && (backup_cnt != {CNT_W{1'b1}}))
                backup_cnt <= backup_cnt + CNT_W'(1);
        end
    end

    assign state_o = state;

    // Active duty only changes at the wrap so a period is never cut short or stretched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt   <= '0;
            duty      <= PWM_W'(DUTY_RST);
            duty_pend <= PWM_W'(DUTY_RST);
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (duty_load)                 duty_pend <= duty_in;
            if (pwm_cnt == {PWM_W{1'b1}}) duty      <= duty_pend;
        end
    end

    assign pwm_on = (pwm_cnt < duty);

    always_comb begin
        cmd[0] = 2'b00;
        cmd[1] = 2'b00;
        case (state)
            ST_FORWARD: begin cmd[0] = 2'b10; cmd[1] = 2'b10; end
            ST_RIGHT:   begin cmd[0] = 2'b10; cmd[1] = 2'b01; end
            ST_LEFT:    begin cmd[0] = 2'b01; cmd[1] = 2'b10; end
            ST_BACKUP:  begin cmd[0] = 2'b01; cmd[1] = 2'b01; end
            default: ;
        endcase
    end

`ifdef DEADTIME_EN
    localparam int DT_W = $clog2(DEADTIME_CYC + 1);
    logic [1:0]      prev_cmd [2];
    logic [DT_W-1:0] hold [2];

    // The reversal cycle itself is the first blanked cycle, so the counter starts at DEADTIME_CYC-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                mot[m]      <= 2'b00;
                prev_cmd[m] <= 2'b00;
                hold[m]     <= '0;
            end
        end else begin
            for (int m = 0; m < 2; m++) begin
                prev_cmd[m] <= cmd[m];
                if ((cmd[m] != 2'b00) && (prev_cmd[m] != 2'b00) && (cmd[m] != prev_cmd[m])) begin
                    hold[m] <= DT_W'(DEADTIME_CYC - 1);
                    mot[m]  <= 2'b00;
                end else if (hold[m] != '0) begin
                    hold[m] <= hold[m] - DT_W'(1);
                    mot[m]  <= 2'b00;
                end else begin
                    mot[m] <= cmd[m] & {2{pwm_on}};
                end
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) mot[m] <= 2'b00;
        end else begin
            for (int m = 0; m < 2; m++) mot[m] <= cmd[m] & {2{pwm_on}};
        end
    end
`endif

    assign motor_out = {mot[0], mot[1]};

endmodule

// File: tb/tb_microbot_nav_pwm_ctrl.sv
// tb/tb_microbot_nav_pwm_ctrl.sv - directed and randomized bench for microbot_nav_pwm_ctrl with behavioural model
module tb_microbot_nav_pwm_ctrl;

    localparam int DEB   = 4;
    localparam int DWELL = 16;
    localparam int BACK  = 32;
    localparam int DT    = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [2:0] sens_raw;
    logic [7:0] duty_in;
    logic       duty_load;
    logic [3:0] motor_out;
    logic [2:0] state_o;
    logic [2:0] sens_db;
    logic [7:0] backup_cnt;

    int vectors = 0;
    int miscompares = 0;

    microbot_nav_pwm_ctrl #(
        .PWM_W(8), .DEBOUNCE_CYC(DEB), .MIN_DWELL(DWELL), .BACKUP_CYC(BACK),
        .CNT_W(8), .DUTY_RST(128), .DEADTIME_CYC(DT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sens_raw(sens_raw), .duty_in(duty_in),
        .duty_load(duty_load), .motor_out(motor_out), .state_o(state_o),
        .sens_db(sens_db), .backup_cnt(backup_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: state as a residence age, sensors as a window over raw history.
    int         dec_tbl [8] = '{1, 3, 2, 1, 2, 3, 2, 4};
    logic [3:0] drive_tbl [5] = '{4'b0000, 4'b1010, 4'b1001, 4'b0110, 4'b0101};
    int         m_state, m_age, m_bcnt, m_cnt, m_duty, m_pend;
    logic [2:0] m_db;
    logic [3:0] m_motor;
    logic [2:0] hist [$];
    logic [1:0] m_prev [2];
    int         m_hold [2];

    task automatic model_reset();
        m_state = 0; m_age = 0; m_bcnt = 0; m_cnt = 0; m_duty = 128; m_pend = 128;
        m_db = 3'b000; m_motor = 4'b0000;
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(3'b000);
        for (int m = 0; m < 2; m++) begin m_prev[m] = 2'b00; m_hold[m] = 0; end
    endtask

    task automatic model_edge();
        int         ns;
        logic       pwm;
        logic [3:0] drv;
        pwm = (m_cnt < m_duty);
        drv = drive_tbl[m_state];
`ifdef DEADTIME_EN
        for (int m = 0; m < 2; m++) begin
            logic [1:0] c;
            c = (m == 0) ? drv[3:2] : drv[1:0];
            if (c != 2'b00 && m_prev[m] != 2'b00 && c != m_prev[m]) m_hold[m] = DT;
            if (m_hold[m] > 0) begin
                c = 2'b00;
                m_hold[m]--;
            end else begin
                c = c & {2{pwm}};
            end
            m_prev[m] = (m == 0) ? drv[3:2] : drv[1:0];
            if (m == 0) m_motor[3:2] = c; else m_motor[1:0] = c;
        end
`else
        m_motor = drv & {4{pwm}};
`endif
        if (!en)               ns = 0;
        else if (m_state == 0) ns = dec_tbl[m_db];
        else if (m_state == 4) ns = (m_age >= BACK - 1) ? 2 : 4;
        else                   ns = (m_age >= DWELL - 1) ? dec_tbl[m_db] : m_state;
        if (ns != m_state) begin
            m_age = 0;
            if (ns == 4 && m_bcnt < 255) m_bcnt++;
        end else begin
            m_age++;
        end
        m_state = ns;
        hist.push_back(sens_raw);
        void'(hist.pop_front());
        for (int b = 0; b < 3; b++) begin
            bit all_diff;
            all_diff = 1'b1;
            for (int k = 0; k < DEB; k++) if (hist[k][b] == m_db[b]) all_diff = 1'b0;
            if (all_diff) m_db[b] = ~m_db[b];
        end
        if (m_cnt == 255) m_duty = m_pend;
        if (duty_load) m_pend = duty_in;
        m_cnt = (m_cnt + 1) % 256;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("state", 32'(state_o), 32'(m_state));
        check("sens_db", 32'(sens_db), 32'(m_db));
        check("backup_cnt", 32'(backup_cnt), 32'(m_bcnt));
        check("motor", 32'(motor_out), 32'(m_motor));
    endtask

    initial begin
        int hi;
        rst_n = 1'b0; en = 1'b0; sens_raw = 3'b000; duty_in = 8'd0; duty_load = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_motor", 32'(motor_out), 32'd0);
        check("rst_sens_db", 32'(sens_db), 32'd0);
        check("rst_backup_cnt", 32'(backup_cnt), 32'd0);
        rst_n = 1'b1;

        // Forward at full duty
        en = 1'b1; duty_in = 8'd255; duty_load = 1'b1;
        step();
        duty_load = 1'b0;
        repeat (300) step();

        // Three-cycle glitch on left must not reach sens_db
        sens_raw = 3'b010;
        repeat (3) step();
        sens_raw = 3'b000;
        repeat (20) step();
        check("glitch_state", 32'(state_o), 32'd1);

        // Full blockage: one back-off then RIGHT
        sens_raw = 3'b111;
        repeat (45) step();
        check("one_backup", 32'(backup_cnt), 32'd1);
        sens_raw = 3'b000;
        repeat (60) step();

        // Duty load at cnt=10 takes effect at the wrap
        while (m_cnt != 10) step();
        duty_in = 8'd64; duty_load = 1'b1;
        step();
        duty_load = 1'b0;
        repeat (600) step();
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (motor_out != 4'b0000) hi++;
        end
        check("duty64_window", 32'(hi), 32'd64);

        // Zero duty keeps motors off
        duty_in = 8'd0; duty_load = 1'b1;
        step();
        duty_load = 1'b0;
        repeat (300) step();
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            step();
            if (motor_out != 4'b0000) hi++;
        end
        check("duty0_window", 32'(hi), 32'd0);

        // Randomized sensors, enable drops and duty loads
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) sens_raw = 3'($urandom_range(0, 7));
            en = ($urandom_range(0, 149) != 0);
            duty_load = ($urandom_range(0, 39) == 0);
            if (duty_load) duty_in = 8'($urandom_range(0, 255));
            step();
        end
        en = 1'b1; duty_load = 1'b0; duty_in = 8'd200; duty_load = 1'b1;
        step();
        duty_load = 1'b0;

        // Held blockage drives the back-off counter into saturation
        sens_raw = 3'b111;
        repeat (260 * (BACK + DWELL)) step();
        check("backup_sat", 32'(backup_cnt), 32'd255);

        // Asynchronous reset between edges while moving forward
        sens_raw = 3'b000;
        repeat (80) step();
        check("pre_reset_fwd", 32'(state_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_state", 32'(state_o), 32'd0);
        check("async_motor", 32'(motor_out), 32'd0);
        check("async_backup_cnt", 32'(backup_cnt), 32'd0);
        check("async_sens_db", 32'(sens_db), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
